// File: rtl/clk_rst_seq.sv
// -----------------------------------------------------------------------------
// clk_rst_seq
//
// Multi-channel divided-clock and reset sequencer. Every channel divides the
// source clock by a programmable half period and owns a small reset FSM that
// holds an active-low reset for a number of divided-clock rising edges. The
// FSM starts out asserted with the power-on hold length after rst_n, and it
// can be re-armed at any time with a mid-test reset request.
//
// Ports
//   clk          in   source clock, all logic on posedge
//   rst_n        in   synchronous active-low reset
//   chan_en_i    in   [NumChan]       per-channel divider enable
//   div_half_i   in   [NumChan*DivW]  half period in clk cycles, channel i at [i*DivW +: DivW]
//   rst_req_i    in   [NumChan]       per-channel reset request (level, sampled every cycle)
//   rst_len_i    in   [RstCntW]       hold length for requested resets (0 acts as 1)
//   clk_o        out  [NumChan]       divided clocks (registered)
//   clk_rise_o   out  [NumChan]       one-cycle strobe in the first cycle clk_o[i] is high
//   rst_no       out  [NumChan]       per-channel active-low reset (registered)
//   rst_done_o   out  [NumChan]       one-cycle strobe in the first cycle rst_no[i] is high again
//   rst_busy_o   out                  high while any channel holds its reset
// -----------------------------------------------------------------------------
module clk_rst_seq #(
    parameter int NumChan   = 2,
    parameter int DivW      = 8,
    parameter int RstCntW   = 8,
    parameter int RstPorLen = 100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NumChan-1:0]      chan_en_i,
    input  logic [NumChan*DivW-1:0] div_half_i,
    input  logic [NumChan-1:0]      rst_req_i,
    input  logic [RstCntW-1:0]      rst_len_i,
    output logic [NumChan-1:0]      clk_o,
    output logic [NumChan-1:0]      clk_rise_o,
    output logic [NumChan-1:0]      rst_no,
    output logic [NumChan-1:0]      rst_done_o,
    output logic                    rst_busy_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ASSERT = 1'b1
    } rst_state_e;

    localparam logic [RstCntW-1:0] PorLen = RstCntW'(RstPorLen);
    localparam logic [RstCntW-1:0] CntOne = RstCntW'(1);
    localparam logic [DivW-1:0]    DivOne = DivW'(1);

    logic [NumChan-1:0] busy;

    // A requested hold of zero would never release; it is treated as one rise.
    logic [RstCntW-1:0] req_len;
    assign req_len = (rst_len_i == '0) ? CntOne : rst_len_i;

    genvar gi;
    generate
        for (gi = 0; gi < NumChan; gi++) begin : g_chan
            logic [DivW-1:0]    half;
            logic               div_active;
            logic [DivW-1:0]    cnt_reg, cnt_next;
            logic               clk_reg, clk_next;
            logic               rise_reg, rise_next;
            rst_state_e         state_reg, state_next;
            logic [RstCntW-1:0] hold_reg, hold_next;
            logic               done_reg, done_next;

            assign half       = div_half_i[gi*DivW +: DivW];
            assign div_active = chan_en_i[gi] && (half != '0);

            // Divider. The >= compare (rather than ==) makes a half period
            // shortened below the running count toggle on the next cycle
            // instead of letting the counter wrap around.
            always_comb begin
                cnt_next  = '0;
                clk_next  = 1'b0;
                rise_next = 1'b0;
                if (div_active) begin
                    if (cnt_reg >= half - DivOne) begin
                        cnt_next  = '0;
                        clk_next  = ~clk_reg;
                        rise_next = ~clk_reg;
                    end else begin
                        cnt_next = cnt_reg + DivOne;
                        clk_next = clk_reg;
                    end
                end
            end

            // Reset FSM. The hold count only moves on rise strobes, so a
            // stopped divider freezes the hold with the reset still asserted.
            // A request always wins over the final strobe.
            always_comb begin
                state_next = state_reg;
                hold_next  = hold_reg;
                done_next  = 1'b0;
                if (state_reg == ST_IDLE) begin
                    if (rst_req_i[gi]) begin
                        state_next = ST_ASSERT;
                        hold_next  = req_len;
                    end
                end else begin
                    if (rst_req_i[gi]) begin
                        hold_next = req_len;
                    end else if (rise_reg) begin
                        if (hold_reg == CntOne) begin
                            state_next = ST_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            hold_next = hold_reg - CntOne;
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg   <= '0;
                    clk_reg   <= 1'b0;
                    rise_reg  <= 1'b0;
                    state_reg <= ST_ASSERT;
                    hold_reg  <= PorLen;
                    done_reg  <= 1'b0;
                end else begin
                    cnt_reg   <= cnt_next;
                    clk_reg   <= clk_next;
                    rise_reg  <= rise_next;
                    state_reg <= state_next;
                    hold_reg  <= hold_next;
                    done_reg  <= done_next;
                end
            end

            assign clk_o[gi]      = clk_reg;
            assign clk_rise_o[gi] = rise_reg;
            assign rst_no[gi]     = (state_reg == ST_IDLE);
            assign rst_done_o[gi] = done_reg;
            assign busy[gi]       = (state_reg == ST_ASSERT);
        end
    endgenerate

    assign rst_busy_o = |busy;

endmodule
